// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Multiplies use radix-2 shift-add on operand magnitudes. Divides use
// restoring division on magnitudes. Both take XLEN CALC cycles. Divide by
// zero and signed overflow finish in a single cycle.
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, all
// multiplies use a single-cycle combinational product instead.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [RDW-1:0]  rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RDW-1:0]  rd_out
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [XLEN-1:0]   X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] P_ZERO   = {(2*XLEN){1'b0}};
    localparam logic [2*XLEN-1:0] P_ONE    = {{(2*XLEN-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement negation helpers at operand and product width.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + X_ONE) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + P_ONE) : v;
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;       // product / quotient sign
    logic              rneg_q, rneg_d;     // remainder sign (sign of a)
    logic [RDW-1:0]    rd_q, rd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RDW-1:0]    rd_out_q, rd_out_d;

    logic              accept_s;
    logic              in_a_neg_s, in_b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0]   special_res_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [2*XLEN-1:0] prod_step_s, prod_fix_s;
    logic [XLEN:0]     shifted_s, diff_s;
    logic [XLEN-1:0]   rem_step_s, quo_step_s;
    logic [XLEN-1:0]   mul_final_s, div_final_s;
    logic              calc_last_s;

    // Request decode: accept condition, operand signs, magnitudes and divide special cases.
    always_comb begin
        accept_s    = start && !kill && (state_q != ST_CALC);
        in_a_neg_s  = a[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU) ||
                                    (op == OP_DIV)  || (op == OP_REM));
        in_b_neg_s  = b[XLEN-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
        a_mag_s     = neg_x(a, in_a_neg_s);
        b_mag_s     = neg_x(b, in_b_neg_s);
        div_zero_s  = op[2] && (b == X_ZERO);
        div_ovf_s   = ((op == OP_DIV) || (op == OP_REM)) && (a == X_MIN) && (b == X_ONES);
        special_s   = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_res_s = op[1] ? a : X_ONES;
        end else if (div_ovf_s) begin
            special_res_s = op[1] ? X_ZERO : a;
        end else begin
            special_res_s = a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;

    // Single-cycle multiply: full magnitude product, sign fix, half select.
    always_comb begin
        fast_s      = !op[2];
        fast_prod_s = neg_p({X_ZERO, a_mag_s} * {X_ZERO, b_mag_s}, in_a_neg_s ^ in_b_neg_s);
        if (op == OP_MUL) begin
            fast_res_s = fast_prod_s[XLEN-1:0];
        end else begin
            fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
        end
    end
`else
    // Iterative multiply only: the single-cycle path is absent.
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = X_ZERO;
    end
`endif

    // One iteration of shift-add multiply and restoring divide, plus final sign fix.
    always_comb begin
        prod_step_s = prod_q + (mplier_q[0] ? mcand_q : P_ZERO);
        shifted_s   = {rem_q, quo_q[XLEN-1]};
        diff_s      = shifted_s - {1'b0, dvs_q};
        rem_step_s  = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
        quo_step_s  = {quo_q[XLEN-2:0], ~diff_s[XLEN]};
        prod_fix_s  = neg_p(prod_step_s, neg_q);
        if (op_q == OP_MUL) begin
            mul_final_s = prod_fix_s[XLEN-1:0];
        end else begin
            mul_final_s = prod_fix_s[2*XLEN-1:XLEN];
        end
        if (op_q[1]) begin
            div_final_s = neg_x(rem_step_s, rneg_q);
        end else begin
            div_final_s = neg_x(quo_step_s, neg_q);
        end
        calc_last_s = (state_q == ST_CALC) && !kill && (cnt_q == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: kill always wins; special divides and fast multiplies skip CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    if (special_s || fast_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // Datapath next state: load magnitudes on accept, iterate while in CALC.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        rd_d     = rd_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        if (accept_s) begin
            cnt_d    = CNT_ZERO;
            op_d     = op;
            neg_d    = in_a_neg_s ^ in_b_neg_s;
            rneg_d   = in_a_neg_s;
            rd_d     = rd_in;
            prod_d   = P_ZERO;
            mcand_d  = {X_ZERO, a_mag_s};
            mplier_d = b_mag_s;
            rem_d    = X_ZERO;
            quo_d    = a_mag_s;
            dvs_d    = b_mag_s;
        end else if ((state_q == ST_CALC) && !kill) begin
            cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : (cnt_q + CNT_ONE);
            prod_d   = prod_step_s;
            mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            rem_d    = rem_step_s;
            quo_d    = quo_step_s;
        end else begin
            cnt_d    = cnt_q;
        end
    end

    // Result and tag next state: update only in the cycle that enters DONE.
    always_comb begin
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (accept_s && special_s) begin
            result_d = special_res_s;
            rd_out_d = rd_in;
        end else if (accept_s && fast_s) begin
            result_d = fast_res_s;
            rd_out_d = rd_in;
        end else if (calc_last_s) begin
            result_d = op_q[2] ? div_final_s : mul_final_s;
            rd_out_d = rd_q;
        end else begin
            result_d = result_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= CNT_ZERO;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            rd_q     <= {RDW{1'b0}};
            prod_q   <= P_ZERO;
            mcand_q  <= P_ZERO;
            mplier_q <= X_ZERO;
            rem_q    <= X_ZERO;
            quo_q    <= X_ZERO;
            dvs_q    <= X_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= X_ZERO;
            rd_out_q <= {RDW{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            rd_q     <= rd_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (XLEN=32): directed cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int RDW  = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic            clk;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RDW-1:0]  rd_in;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RDW-1:0]  rd_out;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(XLEN), .RDW(RDW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .kill(kill), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, up;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = ux * uy; return up[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                up = ux / uy; return up[31:0];
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (ovf) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                up = ux % uy; return up[31:0];
            end
        endcase
    endfunction

    // Expected start-to-done latency in cycles.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return MUL_LAT;
        if (y == 32'd0) return 1;
        if (((f == 3'd4) || (f == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Issue one op (caller is just after a negedge) and wait for done, bounded.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] tag, output int lat, output int bc);
        op = f; a = x; b = y; rd_in = tag; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bc  = 0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) bc++;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; kill = 1'b0; op = 3'd4; a = 32'd99; b = 32'd3; rd_in = 5'd7;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out got=%h exp=0", rd_out); end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mul_basic();
        int lat, bc;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, bc);
        checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, MUL_LAT); end
        checks++; if (bc !== ((MUL_LAT == 1) ? 0 : 32)) begin failures++; $display("FAIL mul_busy_cycles got=%0d", bc); end
        checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", result); end
        checks++; if (rd_out !== 5'd9) begin failures++; $display("FAIL mul_rd_out got=%0d exp=9", rd_out); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
        checks++; if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result_hold got=%h", result); end
    endtask

    task automatic test_high_mul();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] exps[3] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h8000_0000, 32'h8000_0000, 5'(i + 1), lat, bc);
            checks++; if (result !== exps[i]) begin failures++; $display("FAIL high_mul op=%0d got=%h exp=%h", ops[i], result, exps[i]); end
            checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL high_mul_lat op=%0d got=%0d exp=%0d", ops[i], lat, MUL_LAT); end
            @(negedge clk);
        end
    endtask

    task automatic test_signed_div();
        logic [2:0]  ops [3] = '{3'd4, 3'd6, 3'd5};
        logic [31:0] exps[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'hFFFF_FFF9, 32'd2, 5'(i + 10), lat, bc);
            checks++; if (result !== exps[i]) begin failures++; $display("FAIL signed_div op=%0d got=%h exp=%h", ops[i], result, exps[i]); end
            checks++; if ((lat !== 33) || (bc !== 32)) begin failures++; $display("FAIL signed_div_timing op=%0d lat=%0d busy=%0d exp 33/32", ops[i], lat, bc); end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        logic [2:0]  ops [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1234};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'h0000_1234, 32'd0, 5'(i + 20), lat, bc);
            checks++; if (result !== exps[i]) begin failures++; $display("FAIL div_zero op=%0d got=%h exp=%h", ops[i], result, exps[i]); end
            checks++; if ((lat !== 1) || (bc !== 0)) begin failures++; $display("FAIL div_zero_timing op=%0d lat=%0d busy=%0d exp 1/0", ops[i], lat, bc); end
            checks++; if (rd_out !== 5'(i + 20)) begin failures++; $display("FAIL div_zero_rd op=%0d got=%0d exp=%0d", ops[i], rd_out, i + 20); end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic [2:0]  ops [2] = '{3'd4, 3'd6};
        logic [31:0] exps[2] = '{32'h8000_0000, 32'h0000_0000};
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, bc);
            checks++; if (result !== exps[i]) begin failures++; $display("FAIL overflow op=%0d got=%h exp=%h", ops[i], result, exps[i]); end
            checks++; if ((lat !== 1) || (bc !== 0)) begin failures++; $display("FAIL overflow_timing op=%0d lat=%0d busy=%0d exp 1/0", ops[i], lat, bc); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(3'd5, 32'd100, 32'd7, 5'd3, lat, bc);
        checks++; if (result !== 32'd14) begin failures++; $display("FAIL b2b_first got=%h exp=%h", result, 32'd14); end
        // Next start is driven during the DONE cycle.
        run_op(3'd6, 32'hFFFF_FFCE, 32'd7, 5'd4, lat, bc);
        checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_second got=%h exp=ffffffff", result); end
        checks++; if ((lat !== 33) || (bc !== 32)) begin failures++; $display("FAIL b2b_timing lat=%0d busy=%0d exp 33/32", lat, bc); end
        checks++; if (rd_out !== 5'd4) begin failures++; $display("FAIL b2b_rd got=%0d exp=4", rd_out); end
        @(negedge clk);
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        int lat, bc, seen;
        prev = result;
        op = 3'd4; a = 32'd1000; b = 32'd3; rd_in = 5'd11; start = 1'b1;
        @(negedge clk);                  // cycle N+1
        start = 1'b0;
        repeat (9) @(negedge clk);       // cycle N+10
        kill = 1'b1;
        @(negedge clk);                  // cycle N+11
        kill = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", seen); end
        checks++; if (result !== prev) begin failures++; $display("FAIL kill_result_held got=%h exp=%h", result, prev); end

        // Kill then restart right away in the following cycle.
        op = 3'd4; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        run_op(3'd5, 32'd1000, 32'd3, 5'd7, lat, bc);
        checks++; if ((result !== 32'd333) || (rd_out !== 5'd7)) begin failures++; $display("FAIL kill_restart got=%h/%0d exp=%h/7", result, rd_out, 32'd333); end
        checks++; if (lat !== 33) begin failures++; $display("FAIL kill_restart_lat got=%0d exp=33", lat); end
        @(negedge clk);

        // kill and start together: request must be dropped.
        op = 3'd5; a = 32'd50; b = 32'd0; rd_in = 5'd2; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL kill_start_dropped got=%0d exp=0", seen); end
        checks++; if (result !== 32'd333) begin failures++; $display("FAIL kill_start_result got=%h exp=%h", result, 32'd333); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, bc);
        @(negedge clk);
        op = 3'd4; a = 32'd1000; b = 32'd3; rd_in = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_busy got=%b exp=1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00", {busy, done}); end
        checks++; if ((result !== 32'd0) || (rd_out !== 5'd0)) begin failures++; $display("FAIL rst_mid_outputs got=%h/%0d exp=0/0", result, rd_out); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ((busy !== 1'b0) || (done !== 1'b0)) begin failures++; $display("FAIL rst_mid_idle got=%b%b exp=00", busy, done); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7, 0))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(20, 1));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y, exp;
        logic [4:0]  tag;
        int lat, bc, el;
        for (int i = 0; i < 150; i++) begin
            f   = 3'($urandom_range(7, 0));
            x   = pick_operand();
            y   = pick_operand();
            tag = 5'($urandom_range(31, 0));
            exp = ref_model(f, x, y);
            el  = exp_lat(f, x, y);
            run_op(f, x, y, tag, lat, bc);
            checks++; if (result !== exp) begin failures++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", f, x, y, result, exp); end
            checks++; if (rd_out !== tag) begin failures++; $display("FAIL rand_rd op=%0d got=%0d exp=%0d", f, rd_out, tag); end
            checks++; if ((lat !== el) || (bc !== ((el == 1) ? 0 : 32))) begin failures++; $display("FAIL rand_timing op=%0d a=%h b=%h lat=%0d busy=%0d exp_lat=%0d", f, x, y, lat, bc, el); end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_in = 5'd0; reset = 1'b0;
        test_reset();
        test_mul_basic();
        test_high_mul();
        test_signed_div();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
